mem_read_seq: RTL

Read-address sequencer that sits directly upstream of the skewed BRAM read fan-out stage in the matrix-multiply datapath. On a `start` pulse it issues one read per cycle over a contiguous address range (`base_addr` .. `base_addr+len-1`) on a single `rd_en`/`rd_addr` pair, which the fan-out stage then delays by one cycle per bank. It honours a `stall` input and waits for the N-1 cycle skew to drain before pulsing `done`. This tells the controller that the last bank has received its final read.

---
 rtl/mem_read_seq_if.sv | 26 ++
 rtl/mem_read_seq.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_read_seq_if.sv
// Handshake bundle between the matmul controller and the read-address sequencer.
// master = controller side (drives burst requests), slave = sequencer side.
interface mem_read_seq_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] len;
    logic              stall;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              done;

    // start is a request sampled only while idle (no ready); rd_en is a
    // valid-only strobe with rd_addr qualified by it and held otherwise.
    modport master (
        output start, base_addr, len, stall,
        input  rd_en, rd_addr, busy, done
    );

    modport slave (
        input  start, base_addr, len, stall,
        output rd_en, rd_addr, busy, done
    );
endinterface

// File: rtl/mem_read_seq.sv
// Read-address sequencer feeding the skewed BRAM fan-out: issues len contiguous
// reads, then waits N-1 cycles for the per-bank skew to drain before pulsing done.
module mem_read_seq #(
    parameter int N      = 4,
    parameter int ADDR_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_read_seq_if.slave  bus,
    output logic [1:0]     state_o
);
    localparam int DW      = (N > 1) ? $clog2(N) : 1;
    localparam int DLAST_I = (N > 1) ? N - 2 : 0;
    localparam logic [DW-1:0] DLAST = DW'(DLAST_I);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d = bus.base_addr;
                    len_d  = bus.len;
                    dcnt_d = '0;
                    // The first read goes out on the accepting edge so that
                    // rd_en is already high in the first busy cycle.
                    if (bus.len != '0) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = bus.base_addr;
                        cnt_d     = ADDR_W'(1);
                        state_d   = S_READ;
                    end else begin
                        cnt_d   = '0;
                        state_d = (N > 1) ? S_DRAIN : S_DONE;
                    end
                end
            end

            S_READ: begin
                if (cnt_q == len_q) begin
                    dcnt_d  = '0;
                    state_d = (N > 1) ? S_DRAIN : S_DONE;
                end else if (!bus.stall) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q + cnt_q;
                    cnt_d     = cnt_q + ADDR_W'(1);
                end
            end

            S_DRAIN: begin
                // Downstream delay line is free-running, so stall is not consulted.
                if (dcnt_q == DLAST) begin
                    state_d = S_DONE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign state_o     = state_q;

endmodule
